sram_serial_ctrl: RTL and testbench



---
 rtl/sram_serial_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sram_serial_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_serial_ctrl.sv
// sram_serial_ctrl: UART byte-stream command engine in front of an sram_driver.
// 5-byte frames (cmd + 32-bit payload MSB first), 4-byte replies, burst dump/fill.
module sram_serial_ctrl #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              ram_start,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready,
    output logic              busy,
    output logic              overrun
);
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);
    localparam logic [1:0] WB_LAST = 2'(DATA_W / 8 - 1);

    localparam logic [7:0] C_ADDR   = 8'h01;
    localparam logic [7:0] C_LOAD   = 8'h02;
    localparam logic [7:0] C_WRITE  = 8'h03;
    localparam logic [7:0] C_READ   = 8'h04;
    localparam logic [7:0] C_DUMP   = 8'h05;
    localparam logic [7:0] C_FILL   = 8'h06;
    localparam logic [7:0] C_STATUS = 8'h07;

    typedef enum logic [2:0] {
        S_RX, S_EXEC, S_MEM, S_MWAIT, S_TX
    } state_t;

    state_t state, state_nxt;

    logic [39:0]       frame;
    logic [2:0]        byte_cnt;
    logic [GW-1:0]     gap;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] wdata;
    logic [15:0]       cnt;
    logic [31:0]       reply;
    logic [1:0]        tx_idx;
    logic              mw_first;

    logic [7:0]  cmd;
    logic [31:0] pay;
    logic [15:0] n_words;
    logic c_addr, c_load, c_write, c_read;
    logic c_dump, c_fill, c_status;
    logic is_mem_cmd, frame_done, mem_done;

    assign cmd     = frame[39:32];
    assign pay     = frame[31:0];
    assign n_words = pay[15:0];

    assign c_addr   = cmd == C_ADDR;
    assign c_load   = cmd == C_LOAD;
    assign c_write  = cmd == C_WRITE;
    assign c_read   = cmd == C_READ;
    assign c_dump   = cmd == C_DUMP;
    assign c_fill   = cmd == C_FILL;
    assign c_status = cmd == C_STATUS;

    // Bursts of zero length never touch memory.
    assign is_mem_cmd = c_write || c_read ||
                        ((c_dump || c_fill) && n_words != 16'd0);

    assign frame_done = state == S_RX && rx_valid && byte_cnt == 3'd4;
    assign mem_done   = state == S_MWAIT && !mw_first && ram_ready;

    assign busy        = state != S_RX;
    assign ram_address = ptr;
    assign ram_wdata   = wdata;
    assign tx_data     = reply[{tx_idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) state <= S_RX;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_start = 1'b0;
        tx_valid  = 1'b0;
        unique case (state)
            S_RX: begin
                if (frame_done) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (is_mem_cmd)  state_nxt = S_MEM;
                else if (c_dump) state_nxt = S_RX;
                else             state_nxt = S_TX;
            end
            S_MEM: begin
                if (ram_ready) begin
                    ram_start = 1'b1;
                    state_nxt = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (mem_done) begin
                    if (c_fill && cnt != 16'd1) state_nxt = S_MEM;
                    else                        state_nxt = S_TX;
                end
            end
            S_TX: begin
                tx_valid = 1'b1;
                if (tx_ready && tx_idx == 2'd0) begin
                    if (c_dump && cnt != 16'd0) state_nxt = S_MEM;
                    else                        state_nxt = S_RX;
                end
            end
            default: state_nxt = S_RX;
        endcase
        // Nothing leaves the block during the reset cycle itself.
        if (reset) begin
            ram_start = 1'b0;
            tx_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame    <= '0;
            byte_cnt <= '0;
            gap      <= '0;
            ptr      <= '0;
            wdata    <= '0;
            cnt      <= '0;
            reply    <= '0;
            tx_idx   <= '0;
            mw_first <= 1'b0;
            ram_re   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            unique case (state)
                S_RX: begin
                    if (rx_valid) begin
                        frame <= {frame[31:0], rx_data};
                        gap   <= '0;
                        if (byte_cnt == 3'd4) byte_cnt <= '0;
                        else                  byte_cnt <= byte_cnt + 3'd1;
                    end else if (byte_cnt != 3'd0) begin
                        if (gap == GAP_MAX) begin
                            byte_cnt <= '0;
                            gap      <= '0;
                        end else begin
                            gap <= gap + 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    tx_idx <= 2'd3;
                    cnt    <= 16'd1;
                    unique case (1'b1)
                        c_addr: begin
                            ptr   <= pay[ADDR_W-1:0];
                            reply <= pay;
                        end
                        c_load: begin
                            wdata <= pay[DATA_W-1:0];
                            reply <= pay;
                        end
                        c_write: begin
                            ram_re <= 1'b0;
                            reply  <= 32'h3;
                        end
                        c_read: ram_re <= 1'b1;
                        c_dump: begin
                            ram_re <= 1'b1;
                            cnt    <= n_words;
                        end
                        c_fill: begin
                            ram_re <= 1'b0;
                            cnt    <= n_words;
                            reply  <= {16'b0, n_words};
                        end
                        c_status: begin
                            reply   <= {overrun, 15'b0, 16'(ptr)};
                            overrun <= 1'b0;
                        end
                        default: reply <= {24'b0, cmd};
                    endcase
                end
                S_MEM: begin
                    if (ram_ready) mw_first <= 1'b1;
                end
                S_MWAIT: begin
                    mw_first <= 1'b0;
                    if (mem_done) begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 16'd1;
                        if (ram_re) reply <= 32'(ram_rdata);
                        if (c_dump) tx_idx <= WB_LAST;
                    end
                end
                S_TX: begin
                    if (tx_ready && tx_idx != 2'd0)
                        tx_idx <= tx_idx - 2'd1;
                end
                default: ;
            endcase
            if (rx_valid && state != S_RX) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_serial_ctrl.sv
// tb_sram_serial_ctrl: directed checks of the serial SRAM command engine
// against a small behavioural sram_driver with a few cycles of access latency.
module tb_sram_serial_ctrl;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        ram_start;
    logic        ram_re;
    logic [12:0] ram_address;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        ram_ready = 1'b1;
    logic        busy;
    logic        overrun;

    int compared = 0;
    int mismatched = 0;

    sram_serial_ctrl #(
        .ADDR_W (13),
        .DATA_W (8),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .ram_start  (ram_start),
        .ram_re     (ram_re),
        .ram_address(ram_address),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_ready  (ram_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:8191];
    logic [12:0] alog [0:63];
    int          starts = 0;
    int          dly = 0;
    logic [12:0] acc_addr;
    logic        acc_re;
    logic [7:0]  acc_wd;

    // sram_driver model: ready drops for the access, result after 3 cycles.
    always @(posedge clk) begin
        if (ram_start) begin
            if (starts < 64) alog[starts] = ram_address;
            starts = starts + 1;
            acc_addr = ram_address;
            acc_re = ram_re;
            acc_wd = ram_wdata;
            dly = 3;
            ram_ready <= 1'b0;
        end else if (dly > 0) begin
            dly = dly - 1;
            if (dly == 0) begin
                if (acc_re) ram_rdata <= mem[acc_addr];
                else mem[acc_addr] = acc_wd;
                ram_ready <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] p);
        send_byte(c);
        send_byte(p[31:24]);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic recv(input int n, output logic [31:0] v);
        int t;
        v = '0;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!tx_valid && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!tx_valid) begin
                compared++;
                mismatched++;
                $error("FAIL tx_wait: observed no byte expected byte %0d", i);
                return;
            end
            v = {v[23:0], tx_data};
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    task automatic cmd_reply(input logic [7:0] c, input logic [31:0] p,
                             input string tag, input logic [31:0] exp);
        logic [31:0] v;
        send_frame(c, p);
        recv(4, v);
        chk(tag, v, exp);
    endtask

    initial begin
        logic [31:0] v;
        int s0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_ram_start", 32'(ram_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_ram_addr", 32'(ram_address), 32'h0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        chk("rst_ram_re", 32'(ram_re), 32'h0);

        // Basic ADDR / LOAD / WRITE / STATUS.
        cmd_reply(8'h01, 32'h10, "addr_reply", 32'h00000010);
        cmd_reply(8'h02, 32'hA5, "load_reply", 32'h000000A5);
        s0 = starts;
        cmd_reply(8'h03, 32'h0, "write_reply", 32'h00000003);
        chk("write_starts", 32'(starts - s0), 32'd1);
        chk("write_addr", 32'(alog[s0]), 32'h010);
        chk("write_mem", 32'(mem[13'h010]), 32'hA5);
        cmd_reply(8'h07, 32'h0, "status_ptr", 32'h00000011);

        // Pointer wrap at the top of memory.
        cmd_reply(8'h01, 32'h1FFF, "addr_top", 32'h00001FFF);
        s0 = starts;
        cmd_reply(8'h03, 32'h0, "write_top", 32'h00000003);
        chk("write_top_addr", 32'(alog[s0]), 32'h1FFF);
        cmd_reply(8'h07, 32'h0, "status_wrap", 32'h00000000);

        // DUMP with a 50-cycle tx stall mid-stream.
        mem[13'h020] = 8'h11;
        mem[13'h021] = 8'h22;
        mem[13'h022] = 8'h33;
        mem[13'h023] = 8'h44;
        cmd_reply(8'h01, 32'h20, "addr_dump", 32'h00000020);
        s0 = starts;
        send_frame(8'h05, 32'h4);
        recv(1, v);
        chk("dump_b0", v, 32'h11);
        repeat (50) @(negedge clk);
        chk("dump_stall_valid", 32'(tx_valid), 32'h1);
        chk("dump_stall_data", 32'(tx_data), 32'h22);
        recv(3, v);
        chk("dump_rest", v, 32'h00223344);
        repeat (20) @(negedge clk);
        chk("dump_no_trailer", 32'(tx_valid), 32'h0);
        chk("dump_idle", 32'(busy), 32'h0);
        chk("dump_starts", 32'(starts - s0), 32'd4);
        cmd_reply(8'h07, 32'h0, "status_dump", 32'h00000024);

        // FILL of three words.
        cmd_reply(8'h02, 32'h5A, "load_fill", 32'h0000005A);
        cmd_reply(8'h01, 32'h100, "addr_fill", 32'h00000100);
        s0 = starts;
        cmd_reply(8'h06, 32'h3, "fill_reply", 32'h00000003);
        chk("fill_starts", 32'(starts - s0), 32'd3);
        chk("fill_a0", 32'(alog[s0]), 32'h100);
        chk("fill_a1", 32'(alog[s0 + 1]), 32'h101);
        chk("fill_a2", 32'(alog[s0 + 2]), 32'h102);
        chk("fill_mem", 32'(mem[13'h102]), 32'h5A);
        cmd_reply(8'h07, 32'h0, "status_fill", 32'h00000103);

        // Partial frame dropped after the idle timeout.
        cmd_reply(8'h01, 32'h21, "addr_to", 32'h00000021);
        send_byte(8'h01);
        send_byte(8'h00);
        repeat (TO + 1) @(negedge clk);
        cmd_reply(8'h04, 32'h0, "read_after_to", 32'h00000022);
        cmd_reply(8'h07, 32'h0, "status_read", 32'h00000022);

        // Byte arriving while busy sets the sticky overrun.
        cmd_reply(8'h01, 32'h20, "addr_ovr", 32'h00000020);
        send_frame(8'h05, 32'h2);
        send_byte(8'hEE);
        chk("overrun_set", 32'(overrun), 32'h1);
        recv(2, v);
        chk("dump_ovr", v, 32'h00001122);
        cmd_reply(8'h07, 32'h0, "status_ovr", 32'h80000022);
        chk("overrun_clr", 32'(overrun), 32'h0);

        // Unknown command and zero-length bursts.
        s0 = starts;
        cmd_reply(8'h5C, 32'h0, "unknown", 32'h0000005C);
        cmd_reply(8'h06, 32'h0, "fill_zero", 32'h00000000);
        send_frame(8'h05, 32'h0);
        repeat (20) @(negedge clk);
        chk("dump_zero_tx", 32'(tx_valid), 32'h0);
        chk("dump_zero_busy", 32'(busy), 32'h0);
        chk("no_mem_starts", 32'(starts - s0), 32'd0);

        // Reset in the middle of a READ aborts it.
        s0 = starts;
        send_frame(8'h04, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("abort_tx", 32'(tx_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_starts", 32'(starts - s0 <= 1), 32'h1);
        chk("abort_ptr", 32'(ram_address), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
